cp0_exc_unit: RTL and testbench

Coprocessor-0 exception/interrupt unit for the pipelined MIPS core: the receiving end of the 5-bit `ExcCode` produced by the PC and downstream stages. It arbitrates between pending hardware interrupts and the synchronous exception of the instruction at the commit point, and latches EPC, Cause and SR state. It raises the redirect request to the exception handler, serves `mfc0`/`mtc0`, and releases the exception level on `eret`.

---
 rtl/cp0_pkg.sv | 29 ++
 rtl/cp0_exc_arbiter.sv | 26 ++
 rtl/cp0_exc_unit.sv | 124 ++++++++++++
 tb/tb_cp0_exc_unit.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, SR field layout and defaults.
package cp0_pkg;

  localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_REG_SR       = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_REG_EPC      = 5'd14;
  localparam logic [4:0] CP0_REG_PRID     = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] HANDLER_ADDR_DEFAULT = 32'h0000_4180;
  localparam logic [31:0] PRID_VALUE_DEFAULT   = 32'h2019_1116;

  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  function automatic logic is_addr_err(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_exc_arbiter.sv
// Combinational arbitration between pending interrupts and the committing
// instruction's synchronous exception; interrupts take priority.
module cp0_exc_arbiter
  import cp0_pkg::*;
(
  input  logic [5:0] sr_im,
  input  logic       sr_exl,
  input  logic       sr_ie,
  input  logic [5:0] cause_ip,
  input  logic [4:0] exc_code_in,
  output logic       int_pend,
  output logic       exc_pend,
  output logic       exc_req,
  output logic [4:0] sel_code,
  output logic       capture_badvaddr
);

  always_comb begin
    int_pend         = (|(cause_ip & sr_im)) & sr_ie & ~sr_exl;
    exc_pend         = (exc_code_in != EXC_INT) & ~sr_exl;
    exc_req          = int_pend | exc_pend;
    sel_code         = int_pend ? EXC_INT : exc_code_in;
    capture_badvaddr = exc_pend & ~int_pend & is_addr_err(exc_code_in);
  end

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt unit: SR, Cause, EPC, PRId and optional BadVAddr.
// Define CP0_BADVADDR_EN to add the BadVAddr register (reg 8).
module cp0_exc_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEFAULT,
  parameter logic [31:0] PRID_VALUE   = PRID_VALUE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCIn,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        CP0We,
  input  logic [4:0]  CP0Addr,
  input  logic [31:0] CP0WData,
  input  logic        EretIn,
  input  logic [31:0] BadVAddrIn,
  output logic [31:0] CP0RData,
  output logic        ExcReq,
  output logic [31:0] HandlerAddr,
  output logic [31:0] EPCOut
);

  sr_t         sr;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic        int_pend;
  logic        exc_pend;
  logic        exc_req;
  logic [4:0]  sel_code;
  logic        capture_badvaddr;
  logic [31:0] pc_aligned;
  logic [31:0] epc_next;

  cp0_exc_arbiter u_arb (
    .sr_im            (sr.im),
    .sr_exl           (sr.exl),
    .sr_ie            (sr.ie),
    .cause_ip         (cause_ip),
    .exc_code_in      (ExcCodeIn),
    .int_pend         (int_pend),
    .exc_pend         (exc_pend),
    .exc_req          (exc_req),
    .sel_code         (sel_code),
    .capture_badvaddr (capture_badvaddr)
  );

  // A delay-slot instruction restarts at its branch, one word earlier.
  always_comb begin
    pc_aligned = {PCIn[31:2], 2'b00};
    epc_next   = BDIn ? (pc_aligned - 32'd4) : pc_aligned;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr        <= '0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      cause_ip <= HWInt;
      if (exc_req) begin
        sr.exl    <= 1'b1;
        cause_exc <= sel_code;
        cause_bd  <= BDIn;
        epc       <= epc_next;
      end else begin
        if (CP0We && (CP0Addr == CP0_REG_SR)) begin
          sr.im  <= CP0WData[15:10];
          sr.exl <= CP0WData[1];
          sr.ie  <= CP0WData[0];
        end
        if (CP0We && (CP0Addr == CP0_REG_EPC))
          epc <= CP0WData;
        // Placed after the SR write so eret overrides an mtc0 EXL set.
        if (EretIn)
          sr.exl <= 1'b0;
      end
    end
  end

`ifdef CP0_BADVADDR_EN
  logic [31:0] badvaddr;

  always_ff @(posedge clk) begin
    if (reset)
      badvaddr <= '0;
    else if (exc_req && capture_badvaddr)
      badvaddr <= BadVAddrIn;
  end
`else
  logic [31:0] badvaddr;
  logic        unused_badvaddr;

  assign badvaddr        = '0;
  assign unused_badvaddr = ^{BadVAddrIn, capture_badvaddr};
`endif

  logic unused_misc;
  assign unused_misc = ^{PCIn[1:0], exc_pend};

  always_comb begin
    CP0RData = '0;
    case (CP0Addr)
      CP0_REG_BADVADDR: CP0RData = badvaddr;
      CP0_REG_SR:       CP0RData = {16'b0, sr.im, 8'b0, sr.exl, sr.ie};
      CP0_REG_CAUSE:    CP0RData = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};
      CP0_REG_EPC:      CP0RData = epc;
      CP0_REG_PRID:     CP0RData = PRID_VALUE;
      default:          CP0RData = '0;
    endcase
  end

  assign ExcReq      = exc_req;
  assign HandlerAddr = HANDLER_ADDR;
  assign EPCOut      = epc;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Self-checking bench for cp0_exc_unit: register readback expectations are
// queued as stimulus is applied and drained against CP0RData.
module tb_cp0_exc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCIn;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        CP0We;
  logic [4:0]  CP0Addr;
  logic [31:0] CP0WData;
  logic        EretIn;
  logic [31:0] BadVAddrIn;
  logic [31:0] CP0RData;
  logic        ExcReq;
  logic [31:0] HandlerAddr;
  logic [31:0] EPCOut;

  typedef struct {
    string       name;
    logic [4:0]  addr;
    logic [31:0] val;
  } rd_exp_t;

  rd_exp_t sb[$];
  rd_exp_t e;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cp0_exc_unit #(
    .HANDLER_ADDR (32'h0000_4180),
    .PRID_VALUE   (32'h2019_1116)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .PCIn        (PCIn),
    .BDIn        (BDIn),
    .ExcCodeIn   (ExcCodeIn),
    .HWInt       (HWInt),
    .CP0We       (CP0We),
    .CP0Addr     (CP0Addr),
    .CP0WData    (CP0WData),
    .EretIn      (EretIn),
    .BadVAddrIn  (BadVAddrIn),
    .CP0RData    (CP0RData),
    .ExcReq      (ExcReq),
    .HandlerAddr (HandlerAddr),
    .EPCOut      (EPCOut)
  );

  task automatic idle();
    CP0We     = 1'b0;
    EretIn    = 1'b0;
    ExcCodeIn = 5'd0;
    BDIn      = 1'b0;
    CP0Addr   = 5'd0;
    CP0WData  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; HWInt = '0; PCIn = '0; BadVAddrIn = '0;
    idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if (ExcReq !== 1'b0) begin
      miscompares++; $display("FAIL reset_excreq: got %b want 0", ExcReq);
    end
    vectors++;
    if (EPCOut !== 32'h0) begin
      miscompares++; $display("FAIL reset_epcout: got %h want 00000000", EPCOut);
    end
    vectors++;
    if (HandlerAddr !== 32'h0000_4180) begin
      miscompares++; $display("FAIL handler_addr: got %h want 00004180", HandlerAddr);
    end
    sb.push_back('{"reset_sr", 5'd12, 32'h0});
    sb.push_back('{"reset_cause", 5'd13, 32'h0});
    sb.push_back('{"reset_epc", 5'd14, 32'h0});
    sb.push_back('{"reset_prid", 5'd15, 32'h2019_1116});
    sb.push_back('{"reset_badvaddr", 5'd8, 32'h0});
    sb.push_back('{"reset_unmapped", 5'd3, 32'h0});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk); CP0Addr = e.addr; #1;
      vectors++;
      if (CP0RData !== e.val) begin
        miscompares++; $display("FAIL %s: got %h want %h", e.name, CP0RData, e.val);
      end
    end
  endtask

  task automatic test_exception();
    @(negedge clk); PCIn = 32'h3010; BDIn = 1'b0; ExcCodeIn = 5'd12; #1;
    vectors++;
    if (ExcReq !== 1'b1) begin
      miscompares++; $display("FAIL ov_excreq: got %b want 1", ExcReq);
    end
    @(negedge clk); idle(); #1;
    vectors++;
    if (EPCOut !== 32'h3010) begin
      miscompares++; $display("FAIL ov_epcout: got %h want 00003010", EPCOut);
    end
    sb.push_back('{"ov_epc", 5'd14, 32'h3010});
    sb.push_back('{"ov_cause", 5'd13, 32'h0000_0030});
    sb.push_back('{"ov_sr_exl", 5'd12, 32'h0000_0002});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk); CP0Addr = e.addr; #1;
      vectors++;
      if (CP0RData !== e.val) begin
        miscompares++; $display("FAIL %s: got %h want %h", e.name, CP0RData, e.val);
      end
    end
    @(negedge clk); ExcCodeIn = 5'd12; #1;
    vectors++;
    if (ExcReq !== 1'b0) begin
      miscompares++; $display("FAIL exl_mask: got %b want 0", ExcReq);
    end
    @(negedge clk); idle(); EretIn = 1'b1;
    @(negedge clk); idle();
    // delay-slot exception
    @(negedge clk); PCIn = 32'h3010; BDIn = 1'b1; ExcCodeIn = 5'd12; #1;
    vectors++;
    if (ExcReq !== 1'b1) begin
      miscompares++; $display("FAIL bd_excreq: got %b want 1", ExcReq);
    end
    @(negedge clk); idle();
    sb.push_back('{"bd_epc", 5'd14, 32'h300C});
    sb.push_back('{"bd_cause", 5'd13, 32'h8000_0030});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk); CP0Addr = e.addr; #1;
      vectors++;
      if (CP0RData !== e.val) begin
        miscompares++; $display("FAIL %s: got %h want %h", e.name, CP0RData, e.val);
      end
    end
    @(negedge clk); EretIn = 1'b1; CP0Addr = 5'd12; #1;
    vectors++;
    if (CP0RData !== 32'h0000_0002) begin
      miscompares++; $display("FAIL eret_same_cycle_sr: got %h want 00000002", CP0RData);
    end
    @(negedge clk); idle();
    sb.push_back('{"eret_sr", 5'd12, 32'h0});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk); CP0Addr = e.addr; #1;
      vectors++;
      if (CP0RData !== e.val) begin
        miscompares++; $display("FAIL %s: got %h want %h", e.name, CP0RData, e.val);
      end
    end
  endtask

  task automatic test_interrupt();
    @(negedge clk); CP0We = 1'b1; CP0Addr = 5'd12; CP0WData = 32'h0000_FC01; HWInt = 6'b000100; #1;
    vectors++;
    if (ExcReq !== 1'b0) begin
      miscompares++; $display("FAIL int_setup_excreq: got %b want 0", ExcReq);
    end
    @(negedge clk); idle(); PCIn = 32'h2000; ExcCodeIn = 5'd4; #1;
    vectors++;
    if (ExcReq !== 1'b1) begin
      miscompares++; $display("FAIL int_excreq: got %b want 1", ExcReq);
    end
    @(negedge clk); ExcCodeIn = 5'd4; #1;
    vectors++;
    if (ExcReq !== 1'b0) begin
      miscompares++; $display("FAIL int_nested_mask: got %b want 0", ExcReq);
    end
    vectors++;
    if (EPCOut !== 32'h2000) begin
      miscompares++; $display("FAIL int_epcout: got %h want 00002000", EPCOut);
    end
    @(negedge clk); idle();
    sb.push_back('{"int_cause", 5'd13, 32'h0000_1000});
    sb.push_back('{"int_sr", 5'd12, 32'h0000_FC03});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk); CP0Addr = e.addr; #1;
      vectors++;
      if (CP0RData !== e.val) begin
        miscompares++; $display("FAIL %s: got %h want %h", e.name, CP0RData, e.val);
      end
    end
    @(negedge clk); EretIn = 1'b1; #1;
    vectors++;
    if (ExcReq !== 1'b0) begin
      miscompares++; $display("FAIL int_eret_excreq: got %b want 0", ExcReq);
    end
    @(negedge clk); idle(); PCIn = 32'h2100; #1;
    vectors++;
    if (ExcReq !== 1'b1) begin
      miscompares++; $display("FAIL int_refire: got %b want 1", ExcReq);
    end
    @(negedge clk); HWInt = '0; CP0We = 1'b1; CP0Addr = 5'd12; CP0WData = 32'h0; #1;
    vectors++;
    if (ExcReq !== 1'b0) begin
      miscompares++; $display("FAIL int_exl_hold: got %b want 0", ExcReq);
    end
    @(negedge clk); idle();
    sb.push_back('{"int_sr_cleared", 5'd12, 32'h0});
    sb.push_back('{"int_refire_epc", 5'd14, 32'h2100});
    sb.push_back('{"int_cause_ip_low", 5'd13, 32'h0});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk); CP0Addr = e.addr; #1;
      vectors++;
      if (CP0RData !== e.val) begin
        miscompares++; $display("FAIL %s: got %h want %h", e.name, CP0RData, e.val);
      end
    end
  endtask

  task automatic test_mtc0_conflict();
    @(negedge clk); PCIn = 32'h4000; ExcCodeIn = 5'd10; CP0We = 1'b1; CP0Addr = 5'd14; CP0WData = 32'h5000; #1;
    vectors++;
    if (ExcReq !== 1'b1) begin
      miscompares++; $display("FAIL conflict_excreq: got %b want 1", ExcReq);
    end
    @(negedge clk); idle(); CP0We = 1'b1; CP0Addr = 5'd14; CP0WData = 32'h6000; EretIn = 1'b1; #1;
    vectors++;
    if (CP0RData !== 32'h4000) begin
      miscompares++; $display("FAIL conflict_epc_old: got %h want 00004000", CP0RData);
    end
    @(negedge clk); idle();
    sb.push_back('{"mtc0_epc", 5'd14, 32'h6000});
    sb.push_back('{"mtc0_eret_sr", 5'd12, 32'h0});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk); CP0Addr = e.addr; #1;
      vectors++;
      if (CP0RData !== e.val) begin
        miscompares++; $display("FAIL %s: got %h want %h", e.name, CP0RData, e.val);
      end
    end
    @(negedge clk); CP0We = 1'b1; CP0Addr = 5'd13; CP0WData = 32'hFFFF_FFFF;
    @(negedge clk); CP0We = 1'b1; CP0Addr = 5'd12; CP0WData = 32'h0000_FC03; EretIn = 1'b1;
    @(negedge clk); idle();
    sb.push_back('{"cause_ro", 5'd13, 32'h0000_0028});
    sb.push_back('{"mtc0_then_eret", 5'd12, 32'h0000_FC01});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk); CP0Addr = e.addr; #1;
      vectors++;
      if (CP0RData !== e.val) begin
        miscompares++; $display("FAIL %s: got %h want %h", e.name, CP0RData, e.val);
      end
    end
    @(negedge clk); CP0We = 1'b1; CP0Addr = 5'd12; CP0WData = 32'h0;
    @(negedge clk); idle();
  endtask

  task automatic test_badvaddr();
    logic [31:0] want;
`ifdef CP0_BADVADDR_EN
    want = 32'h0000_7F01;
`else
    want = 32'h0;
`endif
    @(negedge clk); PCIn = 32'h3100; ExcCodeIn = 5'd5; BadVAddrIn = 32'h0000_7F01; #1;
    vectors++;
    if (ExcReq !== 1'b1) begin
      miscompares++; $display("FAIL ades_excreq: got %b want 1", ExcReq);
    end
    @(negedge clk); idle(); EretIn = 1'b1;
    @(negedge clk); idle();
    sb.push_back('{"badvaddr_ades", 5'd8, want});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk); CP0Addr = e.addr; #1;
      vectors++;
      if (CP0RData !== e.val) begin
        miscompares++; $display("FAIL %s: got %h want %h", e.name, CP0RData, e.val);
      end
    end
    @(negedge clk); ExcCodeIn = 5'd12; BadVAddrIn = 32'h0000_1234;
    @(negedge clk); idle(); EretIn = 1'b1;
    @(negedge clk); idle();
    sb.push_back('{"badvaddr_ov_hold", 5'd8, want});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk); CP0Addr = e.addr; #1;
      vectors++;
      if (CP0RData !== e.val) begin
        miscompares++; $display("FAIL %s: got %h want %h", e.name, CP0RData, e.val);
      end
    end
  endtask

  task automatic test_reset_mid_exception();
    @(negedge clk); PCIn = 32'h3200; ExcCodeIn = 5'd12;
    @(negedge clk); idle(); reset = 1'b1;
    @(negedge clk); reset = 1'b0; #1;
    vectors++;
    if (ExcReq !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_excreq: got %b want 0", ExcReq);
    end
    vectors++;
    if (EPCOut !== 32'h0) begin
      miscompares++; $display("FAIL rst_mid_epcout: got %h want 00000000", EPCOut);
    end
    sb.push_back('{"rst_mid_sr", 5'd12, 32'h0});
    sb.push_back('{"rst_mid_cause", 5'd13, 32'h0});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk); CP0Addr = e.addr; #1;
      vectors++;
      if (CP0RData !== e.val) begin
        miscompares++; $display("FAIL %s: got %h want %h", e.name, CP0RData, e.val);
      end
    end
  endtask

  initial begin
    test_reset();
    test_exception();
    test_interrupt();
    test_mtc0_conflict();
    test_badvaddr();
    test_reset_mid_exception();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
